// File: rtl/speed_led_pkg.sv
// speed_led_pkg
// Shared types and default sizing for the speed LED bar-graph driver.
//   state_e            : bar FSM state encoding
//   DEF_*              : default parameter values used by speed_bar_led
package speed_led_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD      = 2'd3
  } state_e;

  localparam int DEF_LED_N       = 8;
  localparam int DEF_SEL_W       = 3;
  localparam int DEF_LVL_W       = 4;
  localparam int DEF_BLINK_TICKS = 4;
  localparam int DEF_PEAK_TICKS  = 16;

endpackage : speed_led_pkg

// File: rtl/therm_enc.sv
// therm_enc
// Combinational level decoder.
//   lvl_i  [LVL_W-1:0] : level 0..LED_N
//   bits_o [LED_N-1:0] : ONE_HOT=0 -> low lvl_i bits set (thermometer)
//                        ONE_HOT=1 -> only bit lvl_i-1 set (none when lvl_i=0)
module therm_enc #(
  parameter int LED_N   = 8,
  parameter int LVL_W   = 4,
  parameter bit ONE_HOT = 1'b0
) (
  input  logic [LVL_W-1:0] lvl_i,
  output logic [LED_N-1:0] bits_o
);

  // Per-segment decode of the level.
  always_comb begin
    bits_o = '0;
    for (int i = 0; i < LED_N; i++) begin
      if (ONE_HOT) begin
        bits_o[i] = (lvl_i == LVL_W'(i + 1));
      end else begin
        bits_o[i] = (lvl_i > LVL_W'(i));
      end
    end
  end

endmodule : therm_enc

// File: rtl/speed_bar_led.sv
// speed_bar_led
// Speed-select to LED bar-graph driver. The bar walks toward the target
// min(sw+1, LED_N) one segment per tick; a full bar flashes with a
// half-period of BLINK_TICKS ticks.
// Optional build macro: PEAK_HOLD_EN adds a decaying peak-marker LED.
// Ports:
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   en        : display enable (0 clears the bar)
//   tick      : step strobe, one step per high cycle
//   sw        : speed-select code
//   led       : LED drive, bit0 = lowest segment (registered)
//   level     : current bar length 0..LED_N (registered)
//   at_target : level equals target while enabled (registered)
//   overspeed : level == LED_N (registered)
module speed_bar_led
  import speed_led_pkg::*;
#(
  parameter int LED_N       = DEF_LED_N,
  parameter int SEL_W       = DEF_SEL_W,
  parameter int LVL_W       = DEF_LVL_W,
  parameter int BLINK_TICKS = DEF_BLINK_TICKS,
  parameter int PEAK_TICKS  = DEF_PEAK_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic [SEL_W-1:0] sw,
  output logic [LED_N-1:0] led,
  output logic [LVL_W-1:0] level,
  output logic             at_target,
  output logic             overspeed
);

  localparam int CW = ((SEL_W > LVL_W) ? SEL_W : LVL_W) + 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(LED_N);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [LED_N-1:0] led_q, led_d;
  logic             at_target_q, at_target_d;
  logic             overspeed_q, overspeed_d;
  logic             phase_q, phase_d;
  logic [BW-1:0]    blink_cnt_q, blink_cnt_d;

  logic [CW-1:0]    sw_inc_s;
  logic [LVL_W-1:0] tgt_s;
  logic [LED_N-1:0] bar_bits_s;
  logic [LED_N-1:0] mark_bits_s;

  // Saturating target; widened so sw+1 cannot wrap.
  always_comb begin
    sw_inc_s = CW'(sw) + CW'(1);
    if (sw_inc_s >= CW'(LED_N)) begin
      tgt_s = LVL_MAX;
    end else begin
      tgt_s = LVL_W'(sw_inc_s);
    end
  end

  // Bar FSM next-state and next-level.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (!en) begin
      state_d = IDLE;
      level_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          level_d = '0;
          state_d = RAMP_UP;
        end
        RAMP_UP: begin
          // A target that moved to or below the bar is handled before stepping.
          if (tgt_s == level_q) begin
            state_d = HOLD;
          end else if (tgt_s < level_q) begin
            state_d = RAMP_DOWN;
          end else if (tick) begin
            level_d = level_q + LVL_W'(1);
            if (level_q + LVL_W'(1) == tgt_s) begin
              state_d = HOLD;
            end else begin
              state_d = RAMP_UP;
            end
          end else begin
            state_d = RAMP_UP;
          end
        end
        RAMP_DOWN: begin
          if (tgt_s == level_q) begin
            state_d = HOLD;
          end else if (tgt_s > level_q) begin
            state_d = RAMP_UP;
          end else if (tick) begin
            level_d = level_q - LVL_W'(1);
            if (level_q - LVL_W'(1) == tgt_s) begin
              state_d = HOLD;
            end else begin
              state_d = RAMP_DOWN;
            end
          end else begin
            state_d = RAMP_DOWN;
          end
        end
        HOLD: begin
          if (tgt_s > level_q) begin
            state_d = RAMP_UP;
          end else if (tgt_s < level_q) begin
            state_d = RAMP_DOWN;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          state_d = IDLE;
          level_d = '0;
        end
      endcase
    end
  end

  // Flash phase: only ticks seen while already full advance the counter.
  always_comb begin
    overspeed_d = (level_d == LVL_MAX);
    phase_d     = phase_q;
    blink_cnt_d = blink_cnt_q;
    if (!overspeed_d) begin
      phase_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (overspeed_q && tick) begin
      if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
        phase_d     = ~phase_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  therm_enc #(
    .LED_N   (LED_N),
    .LVL_W   (LVL_W),
    .ONE_HOT (1'b0)
  ) u_bar_enc (
    .lvl_i  (level_d),
    .bits_o (bar_bits_s)
  );

`ifdef PEAK_HOLD_EN
  localparam int HW = $clog2(PEAK_TICKS + 1);

  logic [LVL_W-1:0] peak_q, peak_d;
  logic [HW-1:0]    hold_cnt_q, hold_cnt_d;

  // Peak tracker: raise instantly, hold PEAK_TICKS ticks, then decay to the bar.
  always_comb begin
    peak_d     = peak_q;
    hold_cnt_d = hold_cnt_q;
    if (!en) begin
      peak_d     = '0;
      hold_cnt_d = '0;
    end else if (level_d > peak_q) begin
      peak_d     = level_d;
      hold_cnt_d = '0;
    end else if (tick) begin
      if (hold_cnt_q != HW'(PEAK_TICKS)) begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end else if (peak_q > level_d) begin
        peak_d = peak_q - LVL_W'(1);
      end else begin
        peak_d = peak_q;
      end
    end else begin
      peak_d = peak_q;
    end
  end

  therm_enc #(
    .LED_N   (LED_N),
    .LVL_W   (LVL_W),
    .ONE_HOT (1'b1)
  ) u_peak_enc (
    .lvl_i  (peak_d),
    .bits_o (mark_bits_s)
  );

  // Peak register state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      peak_q     <= peak_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign mark_bits_s = '0;
`endif

  // Output composition; flash-off blanks bar and peak marker alike.
  always_comb begin
    at_target_d = (level_d == tgt_s) && en;
    if (phase_d) begin
      led_d = bar_bits_s | mark_bits_s;
    end else begin
      led_d = '0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      level_q     <= '0;
      led_q       <= '0;
      at_target_q <= 1'b0;
      overspeed_q <= 1'b0;
      phase_q     <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      led_q       <= led_d;
      at_target_q <= at_target_d;
      overspeed_q <= overspeed_d;
      phase_q     <= phase_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign led       = led_q;
  assign level     = level_q;
  assign at_target = at_target_q;
  assign overspeed = overspeed_q;

endmodule : speed_bar_led

// File: tb/tb_speed_bar_led.sv
// tb_speed_bar_led
// Directed bench for speed_bar_led with default parameters (LED_N=8,
// BLINK_TICKS=4, PEAK_TICKS=16). Inputs change on the falling edge and
// outputs are sampled on the falling edge.
module tb_speed_bar_led;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       tick;
  logic [2:0] sw;
  logic [7:0] led;
  logic [3:0] level;
  logic       at_target;
  logic       overspeed;

  int n_cmp;
  int n_err;

  speed_bar_led dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tick      (tick),
    .sw        (sw),
    .led       (led),
    .level     (level),
    .at_target (at_target),
    .overspeed (overspeed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick-high cycle followed by three idle cycles (tick every 4 clks).
  task automatic tick_pulse();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; tick = 1'b1; sw = 3'd7;
    repeat (2) @(negedge clk);
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got %0d want 0", level); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL reset_led got %h want 00", led); end
    n_cmp++; if (at_target !== 1'b0) begin n_err++; $display("FAIL reset_at_target got %b want 0", at_target); end
    n_cmp++; if (overspeed !== 1'b0) begin n_err++; $display("FAIL reset_overspeed got %b want 0", overspeed); end
    rst_n = 1'b1; en = 1'b0; tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp_up();
    sw = 3'b011; en = 1'b1;
    @(negedge clk);
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL up_start got %0d want 0", level); end
    for (int i = 1; i <= 4; i++) begin
      tick_pulse();
      n_cmp++; if (level !== 4'(i)) begin n_err++; $display("FAIL up_level got %0d want %0d", level, i); end
      if (i == 3) begin
        n_cmp++; if (at_target !== 1'b0) begin n_err++; $display("FAIL up_at_target_early got %b want 0", at_target); end
      end
    end
    n_cmp++; if (led !== 8'h0F) begin n_err++; $display("FAIL up_led got %h want 0F", led); end
    n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL up_at_target got %b want 1", at_target); end
  endtask

  task automatic test_ramp_down();
    sw = 3'b001;
    @(negedge clk);
    n_cmp++; if (level !== 4'd4) begin n_err++; $display("FAIL down_transition got %0d want 4", level); end
    tick_pulse();
    n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL down_level3 got %0d want 3", level); end
    tick_pulse();
    n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL down_level2 got %0d want 2", level); end
    n_cmp++; if (led !== 8'h03) begin n_err++; $display("FAIL down_led got %h want 03", led); end
    tick_pulse();
    tick_pulse();
    n_cmp++; if (level !== 4'd2) begin n_err++; $display("FAIL down_undershoot got %0d want 2", level); end
    n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL down_at_target got %b want 1", at_target); end
  endtask

  task automatic test_overspeed_flash();
    logic [7:0] exp_led;
    sw = 3'b111;
    @(negedge clk);
    for (int i = 0; i < 6; i++) tick_pulse();
    n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovs_level got %0d want 8", level); end
    n_cmp++; if (overspeed !== 1'b1) begin n_err++; $display("FAIL ovs_flag got %b want 1", overspeed); end
    n_cmp++; if (led !== 8'hFF) begin n_err++; $display("FAIL ovs_led_first got %h want FF", led); end
    n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL ovs_at_target got %b want 1", at_target); end
    // Ticks 1..3 on, 4..7 off, 8..11 on, 12 off.
    for (int k = 1; k <= 12; k++) begin
      tick_pulse();
      exp_led = ((k >= 4 && k <= 7) || k == 12) ? 8'h00 : 8'hFF;
      n_cmp++; if (led !== exp_led) begin n_err++; $display("FAIL ovs_blink tick %0d got %h want %h", k, led, exp_led); end
      n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL ovs_level_hold tick %0d got %0d want 8", k, level); end
    end
    // Leaving overspeed while dark restores the on phase.
    sw = 3'd6;
    @(negedge clk);
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL ovs_leave_wait got %h want 00", led); end
    tick_pulse();
    n_cmp++; if (level !== 4'd7) begin n_err++; $display("FAIL ovs_leave_level got %0d want 7", level); end
    n_cmp++; if (led !== 8'h7F) begin n_err++; $display("FAIL ovs_leave_led got %h want 7F", led); end
    n_cmp++; if (overspeed !== 1'b0) begin n_err++; $display("FAIL ovs_leave_flag got %b want 0", overspeed); end
  endtask

  task automatic test_min_target();
    sw = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) tick_pulse();
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL min_level got %0d want 1", level); end
    n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL min_led got %h want 01", led); end
    n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL min_at_target got %b want 1", at_target); end
  endtask

  task automatic test_en_drop();
    sw = 3'd7;
    @(negedge clk);
    for (int i = 0; i < 4; i++) tick_pulse();
    n_cmp++; if (level !== 4'd5) begin n_err++; $display("FAIL en_pre_level got %0d want 5", level); end
    en = 1'b0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL en_drop_level got %0d want 0", level); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL en_drop_led got %h want 00", led); end
    n_cmp++; if (at_target !== 1'b0) begin n_err++; $display("FAIL en_drop_at_target got %b want 0", at_target); end
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL en_restart_idle got %0d want 0", level); end
    tick_pulse();
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL en_restart_level got %0d want 1", level); end
  endtask

  task automatic test_reset_mid_ramp();
    tick_pulse();
    tick_pulse();
    n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL rst_pre_level got %0d want 3", level); end
    // Glitch strictly between edges must be ignored.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL rst_glitch_level got %0d want 3", level); end
    rst_n = 1'b0; tick = 1'b1;
    @(negedge clk);
    n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL rst_mid_level got %0d want 0", level); end
    n_cmp++; if (led !== 8'h00) begin n_err++; $display("FAIL rst_mid_led got %h want 00", led); end
    n_cmp++; if (at_target !== 1'b0) begin n_err++; $display("FAIL rst_mid_at_target got %b want 0", at_target); end
    rst_n = 1'b1; tick = 1'b0;
    @(negedge clk);
    tick_pulse();
    n_cmp++; if (level !== 4'd1) begin n_err++; $display("FAIL rst_restart_level got %0d want 1", level); end
  endtask

`ifdef PEAK_HOLD_EN
  task automatic test_peak_hold();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; en = 1'b1; sw = 3'd5;
    @(negedge clk);
    for (int i = 0; i < 6; i++) tick_pulse();
    n_cmp++; if (led !== 8'h3F) begin n_err++; $display("FAIL peak_top_led got %h want 3F", led); end
    sw = 3'd0;
    @(negedge clk);
    for (int k = 1; k <= 21; k++) begin
      tick_pulse();
      if (k == 5 || k == 16) begin
        n_cmp++; if (led !== 8'h21) begin n_err++; $display("FAIL peak_hold tick %0d got %h want 21", k, led); end
      end
      if (k == 17) begin
        n_cmp++; if (led !== 8'h11) begin n_err++; $display("FAIL peak_decay tick %0d got %h want 11", k, led); end
      end
      if (k == 21) begin
        n_cmp++; if (led !== 8'h01) begin n_err++; $display("FAIL peak_meet tick %0d got %h want 01", k, led); end
      end
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0; en = 1'b0; tick = 1'b0; sw = 3'd0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_overspeed_flash();
    test_min_target();
    test_en_drop();
    test_reset_mid_ramp();
`ifdef PEAK_HOLD_EN
    test_peak_hold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_speed_bar_led
